secventiator_cursa: RTL and testbench

//  Race sequencer that gates the movement logic: starts/stops the run, counts laps from the

---
 rtl/secventiator_cursa_pkg.sv | 29 ++
 rtl/secventiator_cursa_filtru_intrare.sv | 48 ++++
 rtl/secventiator_cursa.sv | 164 ++++++++++++++++
 tb/tb_secventiator_cursa.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/secventiator_cursa_pkg.sv
// Shared definitions for the race sequencer: state codes (also exported as the
// debug 'stare' value), circuit selector codes and the circuit -> lap target map.
package secventiator_cursa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_RUN    = 3'd2,
        ST_FINISH = 3'd3,
        ST_FAULT  = 3'd4
    } stare_t;

    localparam logic [1:0] CIRC_ANDUR  = 2'b00;  // endurance, no lap target
    localparam logic [1:0] CIRC_1TURA  = 2'b01;  // one lap
    localparam logic [1:0] CIRC_10TURE = 2'b10;  // ten laps
    localparam logic [1:0] CIRC_REZ    = 2'b11;  // reserved, start is refused

    localparam logic [3:0] COUNT_MAX = 4'd15;

    // Lap target for a circuit; 0 means "no target, run until abort/fault".
    function automatic logic [3:0] tinta_ture(input logic [1:0] c);
        case (c)
            CIRC_1TURA:  tinta_ture = 4'd1;
            CIRC_10TURE: tinta_ture = 4'd10;
            default:     tinta_ture = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/secventiator_cursa_filtru_intrare.sv
// Input conditioner: 2-flop synchroniser followed by a consecutive-sample filter.
// The output rises once DEBOUNCE_CYC consecutive synced-high samples have been
// seen and drops on the first synced-low sample.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   din       raw asynchronous input
//   dout      filtered, clk-synchronous output
module filtru_intrare #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CW'(1);
        out_d = sync2_q && (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign dout = out_q;

endmodule

// File: rtl/secventiator_cursa.sv
// Race sequencer: gates the movement logic (run_en), counts accepted laps from the
// finish-line detector, stops at the per-circuit lap target and faults on line loss.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start, abort synchronous level requests, acted on at their rising edge
//   circuit      00 endurance, 01 one lap, 10 ten laps, 11 reserved
//   tact_count   raw finish-line detect (async)
//   senzor_3     centre line sensor, 1 = on line (async)
//   run_en       movement logic may drive motors
//   count_ture   accepted laps since last start, saturating at 15
//   stop_lamp    brake lamp, lit outside RUN
//   lap_pulse    one-cycle pulse per accepted lap
//   fault        line-loss fault, held until next start or reset
//   stare        state code for debug
module secventiator_cursa
    import secventiator_cursa_pkg::*;
#(
    parameter int DEBOUNCE_CYC    = 16,
    parameter int LAP_LOCKOUT_CYC = 25000000,
    parameter int START_DELAY_CYC = 50000000,
    parameter int LOST_CYC        = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] circuit,
    input  logic       tact_count,
    input  logic       senzor_3,
    output logic       run_en,
    output logic [3:0] count_ture,
    output logic       stop_lamp,
    output logic       lap_pulse,
    output logic       fault,
    output logic [2:0] stare
);
    localparam int KW = $clog2(LAP_LOCKOUT_CYC + 1);
    localparam int DW = $clog2(START_DELAY_CYC + 1);
    localparam int LW = $clog2(LOST_CYC + 1);
    localparam logic [KW-1:0] LOCK_RELOAD = KW'(LAP_LOCKOUT_CYC - 1);
    localparam logic [DW-1:0] DELAY_LAST  = DW'(START_DELAY_CYC - 1);
    localparam logic [LW-1:0] LOST_LAST   = LW'(LOST_CYC - 1);

    logic tact_f, sen_f;

    filtru_intrare #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_filt_tact (
        .clk(clk), .rst(rst), .din(tact_count), .dout(tact_f)
    );
    filtru_intrare #(.DEBOUNCE_CYC(1)) u_filt_sen (
        .clk(clk), .rst(rst), .din(senzor_3), .dout(sen_f)
    );

    stare_t        state_q, state_d;
    logic [3:0]    count_q, count_d;
    logic [1:0]    circ_q, circ_d;
    logic          fault_q, fault_d;
    logic          lap_pulse_q, lap_pulse_d;
    logic [KW-1:0] lock_q, lock_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [LW-1:0] lost_q, lost_d;
    logic          start_prev_q, start_prev_d;
    logic          abort_prev_q, abort_prev_d;
    logic          tact_prev_q, tact_prev_d;

    logic       start_edge, abort_edge, lap_acc, lost_hit;
    logic [3:0] count_next, target;

    assign start_edge = start & ~start_prev_q;
    assign abort_edge = abort & ~abort_prev_q;
    // A lap only counts in RUN and only once the previous lap's lockout has expired.
    assign lap_acc    = (state_q == ST_RUN) && tact_f && !tact_prev_q && (lock_q == '0);
    assign lost_hit   = !sen_f && (lost_q == LOST_LAST);
    assign count_next = (count_q == COUNT_MAX) ? COUNT_MAX : count_q + 4'd1;
    assign target     = tinta_ture(circ_q);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        circ_d       = circ_q;
        fault_d      = fault_q;
        lap_pulse_d  = 1'b0;
        delay_d      = '0;
        lost_d       = '0;
        lock_d       = (lock_q != '0) ? lock_q - KW'(1) : '0;
        start_prev_d = start;
        abort_prev_d = abort;
        tact_prev_d  = tact_f;

        case (state_q)
            ST_IDLE, ST_FINISH, ST_FAULT: begin
                if (start_edge && circuit != CIRC_REZ) begin
                    state_d = ST_START;
                    circ_d  = circuit;
                    count_d = 4'd0;
                    fault_d = 1'b0;
                end
            end
            ST_START: begin
                if (abort_edge)
                    state_d = ST_IDLE;
                else if (delay_q == DELAY_LAST)
                    state_d = ST_RUN;
                else
                    delay_d = delay_q + DW'(1);
            end
            ST_RUN: begin
                // Never overflows: reaching LOST_LAST while low leaves RUN.
                lost_d = sen_f ? '0 : lost_q + LW'(1);
                if (abort_edge) begin
                    state_d = ST_IDLE;
                end else if (lap_acc && target != 4'd0 && count_next == target) begin
                    state_d     = ST_FINISH;
                    count_d     = count_next;
                    lap_pulse_d = 1'b1;
                    lock_d      = LOCK_RELOAD;
                end else if (lost_hit) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else if (lap_acc) begin
                    count_d     = count_next;
                    lap_pulse_d = 1'b1;
                    lock_d      = LOCK_RELOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            circ_q       <= CIRC_ANDUR;
            fault_q      <= 1'b0;
            lap_pulse_q  <= 1'b0;
            lock_q       <= '0;
            delay_q      <= '0;
            lost_q       <= '0;
            start_prev_q <= 1'b0;
            abort_prev_q <= 1'b0;
            tact_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            circ_q       <= circ_d;
            fault_q      <= fault_d;
            lap_pulse_q  <= lap_pulse_d;
            lock_q       <= lock_d;
            delay_q      <= delay_d;
            lost_q       <= lost_d;
            start_prev_q <= start_prev_d;
            abort_prev_q <= abort_prev_d;
            tact_prev_q  <= tact_prev_d;
        end
    end

    assign run_en     = (state_q == ST_RUN);
    assign stop_lamp  = (state_q != ST_RUN);
    assign count_ture = count_q;
    assign lap_pulse  = lap_pulse_q;
    assign fault      = fault_q;
    assign stare      = state_q;

endmodule

// File: tb/tb_secventiator_cursa.sv
module tb_secventiator_cursa;
    localparam int S_IDLE = 0, S_START = 1, S_RUN = 2, S_FINISH = 3, S_FAULT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0;
    logic [1:0] circuit = 2'b00;
    logic       tact_count = 1'b0, senzor_3 = 1'b1;
    logic       run_en, stop_lamp, lap_pulse, fault;
    logic [3:0] count_ture;
    logic [2:0] stare;

    int n_cmp = 0, n_err = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    secventiator_cursa #(
        .DEBOUNCE_CYC(4), .LAP_LOCKOUT_CYC(100), .START_DELAY_CYC(20), .LOST_CYC(50)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .circuit(circuit),
        .tact_count(tact_count), .senzor_3(senzor_3), .run_en(run_en),
        .count_ture(count_ture), .stop_lamp(stop_lamp), .lap_pulse(lap_pulse),
        .fault(fault), .stare(stare)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every lap_pulse pops the next expected lap count.
    always @(negedge clk) begin
        if (!rst && lap_pulse) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_lap: got count %0d expected no lap", count_ture);
            end else begin
                chk("lap_count", int'(count_ture), exp_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [1:0] c);
        circuit = c;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
    endtask

    task automatic tact(input int hi, input int lo);
        tact_count = 1'b1;
        cycles(hi);
        tact_count = 1'b0;
        cycles(lo);
    endtask

    task automatic wait_state(input string name, input int code, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (int'(stare) == code) break;
            cycles(1);
        end
        chk(name, int'(stare), code);
    endtask

    task automatic chk_outputs(input string tag, input int st, input int run,
                               input int cnt, input int lamp, input int flt);
        chk({tag, "_stare"}, int'(stare), st);
        chk({tag, "_run_en"}, int'(run_en), run);
        chk({tag, "_count"}, int'(count_ture), cnt);
        chk({tag, "_stop_lamp"}, int'(stop_lamp), lamp);
        chk({tag, "_fault"}, int'(fault), flt);
    endtask

    task automatic chk_drained(input string name);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1;
        chk_outputs("reset", S_IDLE, 0, 0, 1, 0);
        chk("reset_lap_pulse", int'(lap_pulse), 0);
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // One-lap circuit: single 10-cycle tact pulse finishes the race.
        pulse_start(2'b01);
        chk("a_in_start", int'(stare), S_START);
        wait_state("a_reach_run", S_RUN, 60);
        chk_outputs("a_run", S_RUN, 1, 0, 0, 0);
        exp_q.push_back(1);
        tact(10, 120);
        chk_outputs("a_done", S_FINISH, 0, 1, 1, 0);
        chk_drained("a_drained");

        // Ten-lap circuit; selector changed after start must be ignored.
        pulse_start(2'b10);
        circuit = 2'b01;
        wait_state("b_reach_run", S_RUN, 60);
        for (int i = 1; i <= 10; i++) exp_q.push_back(i);
        for (int i = 0; i < 12; i++) tact(10, 120);
        chk_outputs("b_done", S_FINISH, 0, 10, 1, 0);
        chk_drained("b_drained");

        // Endurance: lockout, glitch rejection, then saturation at 15.
        pulse_start(2'b00);
        wait_state("c_reach_run", S_RUN, 60);
        exp_q.push_back(1);
        tact(10, 20);
        tact(10, 120);
        tact(3, 20);
        chk("c_lockout_count", int'(count_ture), 1);
        chk_drained("c_lockout_drained");
        for (int i = 2; i <= 15; i++) exp_q.push_back(i);
        exp_q.push_back(15);
        exp_q.push_back(15);
        for (int i = 0; i < 16; i++) tact(10, 120);
        chk_outputs("c_sat", S_RUN, 1, 15, 0, 0);
        chk_drained("c_sat_drained");

        // Line loss: 49 low cycles tolerated, 50 faults.
        senzor_3 = 1'b0;
        cycles(49);
        senzor_3 = 1'b1;
        cycles(10);
        chk("d_49_low_run", int'(stare), S_RUN);
        senzor_3 = 1'b0;
        cycles(50);
        senzor_3 = 1'b1;
        cycles(6);
        chk_outputs("d_fault", S_FAULT, 0, 15, 1, 1);

        // New start clears fault; abort in START returns to IDLE.
        pulse_start(2'b01);
        chk_outputs("e_restart", S_START, 0, 0, 1, 0);
        cycles(5);
        pulse_abort();
        chk_outputs("e_abort", S_IDLE, 0, 0, 1, 0);
        cycles(30);
        chk("e_stays_idle", int'(stare), S_IDLE);

        // Reserved circuit start is refused.
        pulse_start(2'b11);
        cycles(2);
        chk("f_reserved_idle", int'(stare), S_IDLE);

        // Async reset mid-RUN, mid-cycle.
        pulse_start(2'b00);
        wait_state("g_reach_run", S_RUN, 60);
        exp_q.push_back(1);
        tact(10, 30);
        chk("g_count", int'(count_ture), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs("g_async_rst", S_IDLE, 0, 0, 1, 0);
        chk("g_rst_lap_pulse", int'(lap_pulse), 0);
        cycles(2);
        rst = 1'b0;
        cycles(5);
        chk("g_after_rst", int'(stare), S_IDLE);
        chk_drained("g_drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
